// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Groups the decode-side hazard inputs and the stall/flush control outputs of
// the hazard sequencer into one bundle.
//
// Optional feature macro: HAZARD_STATS_EN (adds stall_cnt / flush_cnt).
//
// Signals (direction seen from the hazard controller, modport slave):
//   inputs : id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branchreg,
//            id_halt, branch_taken, idex_regwrite, idex_memread, idex_rd,
//            exmem_memread, exmem_rd, mem_busy
//   outputs: pc_stall, ifid_stall, idex_bubble, ifid_flush, halt_done,
//            state[2:0], and with HAZARD_STATS_EN stall_cnt[15:0],
//            flush_cnt[15:0]
// The master modport is the pipeline side that drives decode/ID-EX/EX-MEM
// information and consumes the stall/flush controls.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_W = 4
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_branchreg;
  logic             id_halt;
  logic             branch_taken;
  logic             idex_regwrite;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             exmem_memread;
  logic [REG_W-1:0] exmem_rd;
  logic             mem_busy;

  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             halt_done;
  logic [2:0]       state;
`ifdef HAZARD_STATS_EN
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branchreg,
           id_halt, branch_taken, idex_regwrite, idex_memread, idex_rd,
           exmem_memread, exmem_rd, mem_busy,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, halt_done, state
`ifdef HAZARD_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branchreg,
           id_halt, branch_taken, idex_regwrite, idex_memread, idex_rd,
           exmem_memread, exmem_rd, mem_busy,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, halt_done, state
`ifdef HAZARD_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard and stall sequencer for the 16-bit 5-stage core. Compares the
// instruction in decode against the ID/EX and EX/MEM destinations and the
// memory-busy line, and produces PC / IF-ID stall, ID/EX bubble, IF-ID flush
// and the halt drain sequence.
//
// Optional feature macro: HAZARD_STATS_EN (stall / flush event counters).
//
// Ports:
//   clk  : core clock, all state on rising edge
//   rst  : synchronous active-low reset
//   bus  : hazard_ctrl_if.slave, decode/pipeline info in, controls out
//
// Parameters:
//   REG_W        : register-specifier width
//   DRAIN_CYCLES : cycles after HLT leaves decode before halt_done asserts
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    STALL   = 3'd1,
    MEMWAIT = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [1:0]      r_scnt;
  logic [1:0]      w_nextScnt;
  logic [DW-1:0]   r_dcnt;
  logic [DW-1:0]   w_nextDcnt;

  logic            w_pcStall;
  logic            w_ifidStall;
  logic            w_idexBubble;
  logic            w_ifidFlush;
  logic            w_haltDone;
  logic            w_runMode;

  logic            w_idexSrcMatch;
  logic            w_idexRsMatch;
  logic            w_exmemRsMatch;
  logic            w_loadUse;
  logic            w_brIdexAlu;
  logic            w_brIdexLoad;
  logic            w_brExmemLoad;
  logic [1:0]      w_stallN;

  // Register 0 is hard-wired, so a zero destination never creates a hazard.
  assign w_idexSrcMatch = (bus.idex_rd != '0) &&
                          ((bus.id_uses_rs && (bus.idex_rd == bus.id_rs)) ||
                           (bus.id_uses_rt && (bus.idex_rd == bus.id_rt)));
  // BR reads its target register already in decode, so only rs matters.
  assign w_idexRsMatch  = (bus.idex_rd != '0) && (bus.idex_rd == bus.id_rs);
  assign w_exmemRsMatch = (bus.exmem_rd != '0) && (bus.exmem_rd == bus.id_rs);

  assign w_loadUse     = bus.idex_memread & bus.idex_regwrite & w_idexSrcMatch;
  assign w_brIdexAlu   = bus.id_branchreg & bus.idex_regwrite & ~bus.idex_memread & w_idexRsMatch;
  assign w_brIdexLoad  = bus.id_branchreg & bus.idex_regwrite & bus.idex_memread & w_idexRsMatch;
  assign w_brExmemLoad = bus.id_branchreg & bus.exmem_memread & w_exmemRsMatch;

  // Stall length is the worst case of all hazards that apply this cycle.
  always_comb begin
    w_stallN = 2'd0;
    if (bus.id_valid) begin
      if (w_brIdexLoad)
        w_stallN = 2'd2;
      else if (w_loadUse || w_brIdexAlu || w_brExmemLoad)
        w_stallN = 2'd1;
    end
  end

  // MEMWAIT hands control straight back to the RUN decision on the first
  // cycle the memory is ready, so that cycle behaves exactly like RUN.
  assign w_runMode = (r_state == RUN) || ((r_state == MEMWAIT) && !bus.mem_busy);

  // State register and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
      r_scnt  <= 2'd0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_nextState;
      r_scnt  <= w_nextScnt;
      r_dcnt  <= w_nextDcnt;
    end
  end

  // Next-state and control outputs, in priority mem_busy, hazard, halt, branch.
  always_comb begin
    w_nextState  = r_state;
    w_nextScnt   = r_scnt;
    w_nextDcnt   = r_dcnt;
    w_pcStall    = 1'b0;
    w_ifidStall  = 1'b0;
    w_idexBubble = 1'b0;
    w_ifidFlush  = 1'b0;
    w_haltDone   = 1'b0;

    case (r_state)
      RUN, MEMWAIT: begin
        if (!w_runMode) begin
          w_pcStall   = 1'b1;
          w_ifidStall = 1'b1;
        end else if (bus.mem_busy) begin
          w_pcStall   = 1'b1;
          w_ifidStall = 1'b1;
          w_nextState = MEMWAIT;
        end else if (w_stallN != 2'd0) begin
          w_pcStall    = 1'b1;
          w_ifidStall  = 1'b1;
          w_idexBubble = 1'b1;
          if (w_stallN == 2'd2) begin
            w_nextScnt  = 2'd1;
            w_nextState = STALL;
          end else begin
            w_nextState = RUN;
          end
        end else if (bus.id_valid && bus.id_halt) begin
          w_pcStall   = 1'b1;
          w_ifidFlush = 1'b1;
          w_nextDcnt  = DW'(DRAIN_CYCLES);
          w_nextState = DRAIN;
        end else begin
          w_ifidFlush = bus.branch_taken;
          w_nextState = RUN;
        end
      end

      STALL: begin
        w_pcStall    = 1'b1;
        w_ifidStall  = 1'b1;
        w_idexBubble = 1'b1;
        // A memory stall abandons the count; the hazard is recomputed in RUN.
        if (bus.mem_busy) begin
          w_nextScnt  = 2'd0;
          w_nextState = MEMWAIT;
        end else if (r_scnt <= 2'd1) begin
          w_nextScnt  = 2'd0;
          w_nextState = RUN;
        end else begin
          w_nextScnt = r_scnt - 2'd1;
        end
      end

      DRAIN: begin
        w_pcStall   = 1'b1;
        w_ifidFlush = 1'b1;
        // Older instructions cannot advance while memory is busy.
        if (!bus.mem_busy) begin
          if (r_dcnt <= DW'(1)) begin
            w_nextDcnt  = '0;
            w_nextState = HALTED;
          end else begin
            w_nextDcnt = r_dcnt - DW'(1);
          end
        end
      end

      HALTED: begin
        w_pcStall   = 1'b1;
        w_ifidFlush = 1'b1;
        w_haltDone  = 1'b1;
      end

      default: begin
        w_nextState = RUN;
      end
    endcase
  end

  // All controls are forced quiet while reset is held.
  assign bus.pc_stall    = rst & w_pcStall;
  assign bus.ifid_stall  = rst & w_ifidStall;
  assign bus.idex_bubble = rst & w_idexBubble;
  assign bus.ifid_flush  = rst & w_ifidFlush;
  assign bus.halt_done   = rst & w_haltDone;
  assign bus.state       = rst ? r_state : 3'd0;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stallCnt;
  logic [15:0] r_flushCnt;

  // Saturating event counters, frozen once the core has halted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stallCnt <= 16'd0;
      r_flushCnt <= 16'd0;
    end else if (r_state != HALTED) begin
      if (w_idexBubble && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
      if (w_ifidFlush && w_runMode && (r_flushCnt != 16'hFFFF))
        r_flushCnt <= r_flushCnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stallCnt;
  assign bus.flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// Observed vector layout: {pc_stall, ifid_stall, idex_bubble, ifid_flush,
// halt_done, state[2:0]}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] obs;

  hazard_ctrl_if #(.REG_W(4)) bus ();

  hazard_ctrl #(
    .REG_W(4),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.pc_stall, bus.ifid_stall, bus.idex_bubble, bus.ifid_flush,
                bus.halt_done, bus.state};

  // Return all pipeline inputs to an idle, hazard-free pattern.
  task automatic idle();
    bus.id_valid      = 1'b0;
    bus.id_rs         = 4'd0;
    bus.id_rt         = 4'd0;
    bus.id_uses_rs    = 1'b0;
    bus.id_uses_rt    = 1'b0;
    bus.id_branchreg  = 1'b0;
    bus.id_halt       = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.idex_regwrite = 1'b0;
    bus.idex_memread  = 1'b0;
    bus.idex_rd       = 4'd0;
    bus.exmem_memread = 1'b0;
    bus.exmem_rd      = 4'd0;
    bus.mem_busy      = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    idle();
    nextCycle();
    nextCycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.mem_busy     = 1'b1;
    bus.branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    idle();
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL reset_release got %b expected %b", obs, 8'b00000_000);
    end
  endtask

  task automatic test_load_use();
    nextCycle();
    idle();
    bus.id_valid = 1'b1; bus.id_rs = 4'd3; bus.id_uses_rs = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd3;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_000) begin
      errors++;
      $display("[TB] FAIL loaduse_rs got %b expected %b", obs, 8'b11100_000);
    end
    nextCycle();
    bus.idex_memread = 1'b0; bus.idex_regwrite = 1'b0; bus.idex_rd = 4'd0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL loaduse_release got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    idle();
    bus.id_valid = 1'b1; bus.id_rt = 4'd7; bus.id_uses_rt = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd7;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_000) begin
      errors++;
      $display("[TB] FAIL loaduse_rt got %b expected %b", obs, 8'b11100_000);
    end
    nextCycle();
    bus.id_uses_rt = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL loaduse_unused_src got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    idle();
    bus.id_valid = 1'b1; bus.id_rs = 4'd0; bus.id_uses_rs = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL loaduse_reg0 got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    idle();
  endtask

  task automatic test_branch_reg();
    nextCycle();
    idle();
    bus.id_valid = 1'b1; bus.id_branchreg = 1'b1; bus.id_rs = 4'd5; bus.id_uses_rs = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd5;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_000) begin
      errors++;
      $display("[TB] FAIL br_load_c1 got %b expected %b", obs, 8'b11100_000);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_001) begin
      errors++;
      $display("[TB] FAIL br_load_c2 got %b expected %b", obs, 8'b11100_001);
    end
    nextCycle();
    bus.idex_memread = 1'b0; bus.idex_regwrite = 1'b0; bus.idex_rd = 4'd0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL br_load_c3 got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    bus.id_rs = 4'd0;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL br_load_reg0 got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    bus.id_rs = 4'd6;
    bus.idex_memread = 1'b0; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd6;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_000) begin
      errors++;
      $display("[TB] FAIL br_alu_c1 got %b expected %b", obs, 8'b11100_000);
    end
    nextCycle();
    bus.idex_regwrite = 1'b0; bus.idex_rd = 4'd0;
    bus.exmem_memread = 1'b1; bus.exmem_rd = 4'd6;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_000) begin
      errors++;
      $display("[TB] FAIL br_exmem_load got %b expected %b", obs, 8'b11100_000);
    end
    nextCycle();
    idle();
  endtask

  task automatic test_branch_taken();
    nextCycle();
    idle();
    bus.branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00010_000) begin
      errors++;
      $display("[TB] FAIL taken_flush got %b expected %b", obs, 8'b00010_000);
    end
    nextCycle();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL taken_one_cycle got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    bus.branch_taken = 1'b1;
    bus.id_valid = 1'b1; bus.id_rs = 4'd2; bus.id_uses_rs = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd2;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_000) begin
      errors++;
      $display("[TB] FAIL taken_with_hazard got %b expected %b", obs, 8'b11100_000);
    end
    nextCycle();
    idle();
  endtask

  task automatic test_memwait();
    nextCycle();
    idle();
    bus.mem_busy = 1'b1;
    bus.id_valid = 1'b1; bus.id_rs = 4'd4; bus.id_uses_rs = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd4;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11000_000) begin
      errors++;
      $display("[TB] FAIL run_membusy got %b expected %b", obs, 8'b11000_000);
    end
    nextCycle();
    idle();
    nextCycle();
    bus.id_valid = 1'b1; bus.id_branchreg = 1'b1; bus.id_rs = 4'd9; bus.id_uses_rs = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd9;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_000) begin
      errors++;
      $display("[TB] FAIL mw_enter_c1 got %b expected %b", obs, 8'b11100_000);
    end
    nextCycle();
    bus.mem_busy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL mw_in_stall got %0d expected %0d", bus.state, 1);
    end
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      @(negedge clk);
      checks++;
      if (obs !== 8'b11000_010) begin
        errors++;
        $display("[TB] FAIL mw_wait%0d got %b expected %b", i, obs, 8'b11000_010);
      end
    end
    nextCycle();
    bus.mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_010) begin
      errors++;
      $display("[TB] FAIL mw_exit_reeval got %b expected %b", obs, 8'b11100_010);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (obs !== 8'b11100_001) begin
      errors++;
      $display("[TB] FAIL mw_restall got %b expected %b", obs, 8'b11100_001);
    end
    nextCycle();
    idle();
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL mw_back_to_run got %b expected %b", obs, 8'b00000_000);
    end
  endtask

  task automatic test_halt();
    nextCycle();
    idle();
    bus.id_valid = 1'b1; bus.id_halt = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 8'b10010_000) begin
      errors++;
      $display("[TB] FAIL halt_issue got %b expected %b", obs, 8'b10010_000);
    end
    for (int i = 1; i <= 5; i++) begin
      nextCycle();
      idle();
      bus.mem_busy = (i == 2);
      @(negedge clk);
      checks++;
      if (obs !== 8'b10010_011) begin
        errors++;
        $display("[TB] FAIL drain_c%0d got %b expected %b", i, obs, 8'b10010_011);
      end
    end
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      idle();
      bus.branch_taken = (i == 1);
      bus.mem_busy = (i == 1);
      @(negedge clk);
      checks++;
      if (obs !== 8'b10011_100) begin
        errors++;
        $display("[TB] FAIL halted_%0d got %b expected %b", i, obs, 8'b10011_100);
      end
    end
    nextCycle();
    idle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL halt_reset_low got %b expected %b", obs, 8'b00000_000);
    end
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 8'b00000_000) begin
      errors++;
      $display("[TB] FAIL halt_reset_release got %b expected %b", obs, 8'b00000_000);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    applyReset();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.id_valid = 1'b1; bus.id_rs = 4'd1; bus.id_uses_rs = 1'b1;
      bus.idex_memread = 1'b1; bus.idex_regwrite = 1'b1; bus.idex_rd = 4'd1;
      nextCycle();
      idle();
      nextCycle();
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      bus.branch_taken = 1'b1;
      nextCycle();
      idle();
      nextCycle();
    end
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 16'd3) begin
      errors++;
      $display("[TB] FAIL stats_stall got %0d expected %0d", bus.stall_cnt, 3);
    end
    checks++;
    if (bus.flush_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL stats_flush got %0d expected %0d", bus.flush_cnt, 2);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_branch_reg();
    test_branch_taken();
    test_memwait();
    test_halt();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 16-bit, 5-stage core.
- Watches the instruction in decode (source regs, branch/halt flags) against ID/EX and EX/MEM destination info and the memory-busy line.
- Drives PC/IF-ID stall, ID/EX bubble insertion, IF-ID flush and halt drain.
- Sits beside the decode stage; owns the only stall/flush state in the core.

Parameters:
- REG_W, 4, register-specifier width
- DRAIN_CYCLES, 4, cycles after HLT leaves decode before halt_done asserts (EX, MEM, WB plus 1 margin)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  decode holds a real instruction
- id_rs  in  REG_W  decode source 1 specifier
- id_rt  in  REG_W  decode source 2 specifier
- id_uses_rs  in  1  decode instruction reads id_rs
- id_uses_rt  in  1  decode instruction reads id_rt
- id_branchreg  in  1  decode holds BR (target read in ID)
- id_halt  in  1  decode holds HLT
- branch_taken  in  1  branch resolved taken in ID this cycle
- idex_regwrite  in  1  ID/EX instruction writes a register
- idex_memread  in  1  ID/EX instruction is a load
- idex_rd  in  REG_W  ID/EX destination
- exmem_memread  in  1  EX/MEM instruction is a load
- exmem_rd  in  REG_W  EX/MEM destination
- mem_busy  in  1  memory system not ready (cache miss)
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- idex_bubble  out  1  load NOP into ID/EX
- ifid_flush  out  1  clear IF/ID register
- halt_done  out  1  pipeline drained after HLT, sticky
- state  out  3  FSM state, debug

Behaviour:
- States: RUN=0, STALL=1, MEMWAIT=2, DRAIN=3, HALTED=4. 2-bit stall counter scnt; drain counter dcnt, width clog2(DRAIN_CYCLES+1).
- Reset (rst==0 at posedge): state=RUN, scnt=0, dcnt=0, halt_done=0. All outputs 0 while rst low.
- Reg 0 never matches: a match requires rd!=0 and rd equal to a source that is used.
- Hazard stall count n, computed in RUN with id_valid:
  - Load-use: idex_memread & idex_regwrite & match(idex_rd) gives n=1.
  - BR only (id_branchreg, rs match):
    - idex non-load write match gives n=1.
    - idex load match gives n=2.
    - exmem_memread match gives n=1.
  - n is the maximum of all applicable cases; 0 if none.
- Priority, highest first: mem_busy, hazard, halt, branch_taken.
- RUN:
  - mem_busy=1: pc_stall=ifid_stall=1, bubble=0, flush=0; next MEMWAIT.
  - Else n>0: pc_stall=ifid_stall=idex_bubble=1 this cycle. If n=2, load scnt=1 and go to STALL; else stay in RUN. branch_taken is ignored while stalled.
  - Else id_valid & id_halt: pc_stall=1, ifid_flush=1; dcnt=DRAIN_CYCLES; next DRAIN.
  - Else branch_taken: ifid_flush=1 for this cycle only.
- STALL: pc_stall=ifid_stall=idex_bubble=1. scnt decrements; at 0, go to RUN. mem_busy in STALL goes to MEMWAIT; the hazard is re-evaluated on return.
- MEMWAIT: pc_stall=ifid_stall=1, no bubble, no flush. Leave on the first cycle mem_busy=0 and go to RUN. The RUN outputs are combinational, so they take effect that same cycle.
- DRAIN:
  - pc_stall=1, ifid_flush=1.
  - dcnt decrements only while mem_busy=0.
  - On the cycle dcnt is 1 and decrements to 0, next state is HALTED.
- HALTED: halt_done=1, pc_stall=1, ifid_flush=1; held until reset.
- Reset mid-stall, mid-drain or in HALTED: returns to RUN next cycle, counters cleared.
- Outputs are combinational from state plus inputs. No output depends on itself.

Optional Feature:
HAZARD_STATS_EN
- Defined:
  - Adds outputs stall_cnt[15:0] (+1 each cycle idex_bubble=1) and flush_cnt[15:0] (+1 each cycle ifid_flush=1 in RUN).
  - Both counters saturate at 16'hFFFF, are cleared by reset, and do not count in HALTED.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: idex_memread=1, idex_regwrite=1, idex_rd=3, id_rs=3, id_uses_rs=1 -> exactly 1 cycle of pc_stall/ifid_stall/idex_bubble, state stays 0.
- BR after load: id_branchreg=1, id_rs=5, idex load rd=5 -> stall/bubble 2 cycles (state 0 then 1), RUN on 3rd cycle; same with rd=0 -> no stall.
- Branch taken, no hazard -> ifid_flush=1 for one cycle, pc_stall=0; taken plus load-use hazard -> stall, no flush.
- mem_busy high for 3 cycles during STALL -> MEMWAIT for 3 cycles, no bubble, then RUN and hazard re-evaluated.
- HLT in decode, DRAIN_CYCLES=4, mem_busy pulsed once mid-drain -> halt_done rises 5 cycles after entering DRAIN, stays high; rst=0 for one cycle -> halt_done=0, state=0.
- With HAZARD_STATS_EN: 3 load-use events and 2 taken branches -> stall_cnt=3, flush_cnt=2.
